// File: rtl/i2s_tx_pingpong.sv
// I2S playback transmitter: two ping-pong frame banks filled from the DSP side,
// serialized MSB-first onto the DAC data line from the shared ADC BCK/LRCK.
module i2s_tx_pingpong #(
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned SAMPLE_SIZE   = 24,
    parameter int unsigned BUFF_PTR_BITS = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_bck,
    input  logic                     i_lrck,
    input  logic                     i_wr_en,
    input  logic [2*SAMPLE_SIZE-1:0] i_wr_data,
    output logic                     o_wr_ready,
    output logic                     o_dout,
    output logic                     o_active_bank,
    output logic                     o_underrun,
    output logic                     o_overflow
);
    localparam int unsigned PAD   = WORD_SIZE - SAMPLE_SIZE;
    localparam int unsigned DEPTH = 1 << BUFF_PTR_BITS;

    typedef logic [BUFF_PTR_BITS-1:0] ptr_t;
    localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);

    // Both banks in one array, addressed {bank, frame}.
    logic [2*SAMPLE_SIZE-1:0] mem [2*DEPTH];

    logic                   bck_q;
    logic                   lrck_last;
    logic                   active;
    logic                   active_valid;
    logic                   fill_full;
    ptr_t                   wr_ptr;
    ptr_t                   rd_ptr;
    logic [WORD_SIZE-1:0]   shreg;
    logic [SAMPLE_SIZE-1:0] r_hold;

    logic                     bck_fall;
    logic                     boundary;
    logic                     left_edge;
    logic                     right_edge;
    logic                     wr_accept;
    logic                     do_swap;
    logic [BUFF_PTR_BITS:0]   rd_addr;
    logic [2*SAMPLE_SIZE-1:0] rd_word;

    assign bck_fall   = bck_q & ~i_bck;
    assign boundary   = bck_fall & (i_lrck != lrck_last);
    assign left_edge  = boundary & ~i_lrck;
    assign right_edge = boundary & i_lrck;
    assign wr_accept  = i_wr_en & ~fill_full;
    assign do_swap    = left_edge & ~active_valid & fill_full;

    // On a swap the first frame comes from the bank about to become active.
    always_comb begin
        rd_addr = {active, rd_ptr};
        if (do_swap) begin
            rd_addr = {~active, ptr_t'(0)};
        end
    end

    assign rd_word = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{~active, wr_ptr}] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bck_q        <= 1'b0;
            lrck_last    <= 1'b0;
            active       <= 1'b0;
            active_valid <= 1'b0;
            fill_full    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            shreg        <= '0;
            r_hold       <= '0;
            o_dout       <= 1'b0;
            o_underrun   <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            bck_q      <= i_bck;
            o_underrun <= 1'b0;
            o_overflow <= i_wr_en & fill_full;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == PTR_LAST) begin
                    fill_full <= 1'b1;
                end
            end

            if (bck_fall) begin
                lrck_last <= i_lrck;
                o_dout    <= shreg[WORD_SIZE-1];
                if (left_edge) begin
                    if (active_valid) begin
                        shreg  <= {rd_word[2*SAMPLE_SIZE-1 -: SAMPLE_SIZE], {PAD{1'b0}}};
                        r_hold <= rd_word[SAMPLE_SIZE-1:0];
                        rd_ptr <= rd_ptr + 1'b1;
                        if (rd_ptr == PTR_LAST) begin
                            active_valid <= 1'b0;
                        end
                    end else if (fill_full) begin
                        active       <= ~active;
                        fill_full    <= 1'b0;
                        wr_ptr       <= '0;
                        active_valid <= 1'b1;
                        shreg        <= {rd_word[2*SAMPLE_SIZE-1 -: SAMPLE_SIZE], {PAD{1'b0}}};
                        r_hold       <= rd_word[SAMPLE_SIZE-1:0];
                        rd_ptr       <= ptr_t'(1);
                    end else begin
                        shreg      <= '0;
                        r_hold     <= '0;
                        o_underrun <= 1'b1;
                    end
                end else if (right_edge) begin
                    shreg <= {r_hold, {PAD{1'b0}}};
                end else begin
                    shreg <= {shreg[WORD_SIZE-2:0], 1'b0};
                end
            end
        end
    end

    assign o_wr_ready    = ~fill_full;
    assign o_active_bank = active;

endmodule
